// File: rtl/gemm_operand_sequencer.sv
// Buffers A columns / B rows for a 2x2 GEMM and replays them as lane-skewed
// streams (lane i delayed by i cycles) toward the input manager.
module gemm_operand_sequencer #(
    parameter int OP_WIDTH = 8,
    parameter int K_MAX    = 8,
    parameter int K_W      = $clog2(K_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [2*OP_WIDTH-1:0] load_a_column,
    input  logic [2*OP_WIDTH-1:0] load_b_row,
    output logic [K_W-1:0]        load_count,
    input  logic                  start,
    input  logic [K_W-1:0]        k_len,
    output logic                  start_err,
    output logic                  busy,
    output logic                  done,
    output logic [2*OP_WIDTH-1:0] new_a_column,
    output logic [2*OP_WIDTH-1:0] new_b_row,
    output logic [1:0]            new_a_column_ena,
    output logic [1:0]            new_b_row_ena
);

    localparam int LW    = 2 * OP_WIDTH;
    localparam int IDX_W = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [K_W-1:0]  load_count_q, load_count_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [K_W-1:0]  t_q, t_d;
    logic [LW-1:0]   a_q, a_d;
    logic [LW-1:0]   b_q, b_d;
    logic [1:0]      a_ena_q, a_ena_d;
    logic [1:0]      b_ena_q, b_ena_d;
    logic            done_q, done_d;
    logic            start_err_q, start_err_d;

    logic [LW-1:0]   a_mem [K_MAX];
    logic [LW-1:0]   b_mem [K_MAX];

    logic [LW-1:0]   lane_a;
    logic [LW-1:0]   lane_b;
    logic [1:0]      lane_ena;
    logic            load_fire;
    logic            start_accept;
    logic            start_ok;

    // The done cycle still counts as busy, so neither loads nor starts are taken there.
    assign load_ready   = (state_q == IDLE) && !done_q && (load_count_q < K_W'(K_MAX));
    assign load_fire    = load_valid && load_ready;
    assign start_accept = (state_q == IDLE) && !done_q && start;
    assign start_ok     = (k_len != '0) && (k_len <= load_count_q);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            localparam logic [K_W-1:0] OFS = K_W'(gi);
            logic [K_W-1:0]   lane_t;
            logic [IDX_W-1:0] idx;

            assign lane_t       = t_q - OFS;
            assign idx          = lane_t[IDX_W-1:0];
            assign lane_ena[gi] = (t_q >= OFS) && (lane_t < k_q);
            assign lane_a[gi*OP_WIDTH +: OP_WIDTH] =
                lane_ena[gi] ? a_mem[idx][gi*OP_WIDTH +: OP_WIDTH] : '0;
            assign lane_b[gi*OP_WIDTH +: OP_WIDTH] =
                lane_ena[gi] ? b_mem[idx][gi*OP_WIDTH +: OP_WIDTH] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (load_fire) begin
            a_mem[load_count_q[IDX_W-1:0]] <= load_a_column;
            b_mem[load_count_q[IDX_W-1:0]] <= load_b_row;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_count_d = load_count_q;
        k_d          = k_q;
        t_d          = t_q;
        a_d          = '0;
        b_d          = '0;
        a_ena_d      = '0;
        b_ena_d      = '0;
        done_d       = 1'b0;
        start_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    load_count_d = load_count_q + 1'b1;
                end
                if (start_accept) begin
                    if (start_ok) begin
                        k_d     = k_len;
                        t_d     = '0;
                        state_d = STREAM;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                a_d     = lane_a;
                b_d     = lane_b;
                a_ena_d = lane_ena;
                b_ena_d = lane_ena;
                t_d     = t_q + 1'b1;
                if (t_q == k_q) begin
                    done_d       = 1'b1;
                    state_d      = IDLE;
                    load_count_d = '0;
                    t_d          = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            load_count_q <= '0;
            k_q          <= '0;
            t_q          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            a_ena_q      <= '0;
            b_ena_q      <= '0;
            done_q       <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_count_q <= load_count_d;
            k_q          <= k_d;
            t_q          <= t_d;
            a_q          <= a_d;
            b_q          <= b_d;
            a_ena_q      <= a_ena_d;
            b_ena_q      <= b_ena_d;
            done_q       <= done_d;
            start_err_q  <= start_err_d;
        end
    end

    assign load_count       = load_count_q;
    assign start_err        = start_err_q;
    assign busy             = (state_q == STREAM) || done_q;
    assign done             = done_q;
    assign new_a_column     = a_q;
    assign new_b_row        = b_q;
    assign new_a_column_ena = a_ena_q;
    assign new_b_row_ena    = b_ena_q;

endmodule
